circle_layer_renderer: RTL and testbench

- Parametrised VGA pixel generator: draws up to NUM_OBJ filled circles of configurable radius and colour over a configurable background colour.
- Sits between the VGA timing generator (Hactive/Vactive) and the DAC RGB outputs.
- Keeps its own pixel row/column counters.
- Object positions are double-buffered per frame, so moving objects never tear.
- Uses a 3-stage pipeline for the distance test, which makes 25 MHz timing comfortable.

---
 rtl/circle_layer_renderer.sv | 147 ++++++++++++++
 tb/tb_circle_layer_renderer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_layer_renderer.sv
// VGA layer that draws up to NUM_OBJ filled circles over a background colour.
// Three-stage distance pipeline; circle centres are latched during vertical blanking.
module circle_layer_renderer #(
  parameter int                    NUM_OBJ = 2,
  parameter int                    ROW_W   = 9,
  parameter int                    COL_W   = 10,
  parameter int                    RADIUS  = 30,
  parameter logic [23:0]           BG_RGB  = 24'hFFFFFF,
  // object 0 occupies the low 24 bits: blue, object 1 red
  parameter logic [24*NUM_OBJ-1:0] OBJ_RGB = {24'hFF0000, 24'h0000FF}
) (
  input  logic                     clk25,
  input  logic                     rst,
  input  logic                     Hactive,
  input  logic                     Vactive,
  input  logic                     enable,
  input  logic [NUM_OBJ*ROW_W-1:0] obj_row,
  input  logic [NUM_OBJ*COL_W-1:0] obj_col,
  input  logic [NUM_OBJ-1:0]       obj_en,
  output logic [7:0]               R,
  output logic [7:0]               G,
  output logic [7:0]               B,
  output logic                     de_out
);

  localparam int D2_W = 2*COL_W + 1;
  localparam logic [D2_W-1:0] R2 = D2_W'(RADIUS*RADIUS);

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic                     hactive_d;
  logic [NUM_OBJ*ROW_W-1:0] srow;
  logic [NUM_OBJ*COL_W-1:0] scol;
  logic [NUM_OBJ-1:0]       sen;

  logic [COL_W-1:0]         dx_c  [NUM_OBJ];
  logic [ROW_W-1:0]         dy_c  [NUM_OBJ];
  logic [COL_W-1:0]         dx_s1 [NUM_OBJ];
  logic [ROW_W-1:0]         dy_s1 [NUM_OBJ];
  logic [NUM_OBJ-1:0]       oen_s1;
  logic                     en_s1, de_s1;

  logic [D2_W-1:0]          d2_c  [NUM_OBJ];
  logic [NUM_OBJ-1:0]       hit_c;
  logic [NUM_OBJ-1:0]       hit_s2;
  logic                     en_s2, de_s2;

  logic [23:0]              rgb_c;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      hactive_d <= 1'b0;
      srow      <= '0;
      scol      <= '0;
      sen       <= '0;
    end else begin
      hactive_d <= Hactive;
      if (!Hactive)
        col <= '0;
      else if (Vactive && col != '1)
        col <= col + 1'b1;
      if (!Vactive)
        row <= '0;
      else if (hactive_d && !Hactive && row != '1)
        row <= row + 1'b1;
      // positions only follow the inputs during vertical blanking so a frame never tears
      if (!Vactive) begin
        srow <= obj_row;
        scol <= obj_col;
        sen  <= obj_en;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      dx_c[i] = (col >= scol[i*COL_W +: COL_W]) ? col - scol[i*COL_W +: COL_W]
                                                : scol[i*COL_W +: COL_W] - col;
      dy_c[i] = (row >= srow[i*ROW_W +: ROW_W]) ? row - srow[i*ROW_W +: ROW_W]
                                                : srow[i*ROW_W +: ROW_W] - row;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        dx_s1[i] <= '0;
        dy_s1[i] <= '0;
      end
      oen_s1 <= '0;
      en_s1  <= 1'b0;
      de_s1  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        dx_s1[i] <= dx_c[i];
        dy_s1[i] <= dy_c[i];
      end
      oen_s1 <= sen;
      en_s1  <= enable;
      de_s1  <= Hactive & Vactive;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      d2_c[i]  = D2_W'(dx_s1[i]) * D2_W'(dx_s1[i]) + D2_W'(dy_s1[i]) * D2_W'(dy_s1[i]);
      hit_c[i] = oen_s1[i] && (d2_c[i] <= R2);
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      hit_s2 <= '0;
      en_s2  <= 1'b0;
      de_s2  <= 1'b0;
    end else begin
      hit_s2 <= hit_c;
      en_s2  <= en_s1;
      de_s2  <= de_s1;
    end
  end

  // scan from the top index down so the lowest-index hit is the one left standing
  always_comb begin
    rgb_c = BG_RGB;
    for (int i = NUM_OBJ-1; i >= 0; i--)
      if (hit_s2[i]) rgb_c = OBJ_RGB[24*i +: 24];
    if (!(de_s2 && en_s2)) rgb_c = '0;
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      R      <= '0;
      G      <= '0;
      B      <= '0;
      de_out <= 1'b0;
    end else begin
      R      <= rgb_c[23:16];
      G      <= rgb_c[15:8];
      B      <= rgb_c[7:0];
      de_out <= de_s2;
    end
  end

endmodule

// File: tb/tb_circle_layer_renderer.sv
// Scoreboard bench for circle_layer_renderer: driver pushes expected pixels, monitor
// pops and compares three clocks later; hand-computed spot pixels are checked on top.
module tb_circle_layer_renderer;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        Hactive = 1'b0;
  logic        Vactive = 1'b0;
  logic        enable = 1'b1;
  logic [17:0] obj_row = '0;
  logic [19:0] obj_col = '0;
  logic [1:0]  obj_en = '0;
  logic [7:0]  R, G, B;
  logic        de_out;

  circle_layer_renderer dut (
    .clk25(clk25), .rst(rst), .Hactive(Hactive), .Vactive(Vactive), .enable(enable),
    .obj_row(obj_row), .obj_col(obj_col), .obj_en(obj_en),
    .R(R), .G(G), .B(B), .de_out(de_out)
  );

  always #20 clk25 = ~clk25;

  typedef struct {
    int          due;
    logic        de;
    logic [23:0] rgb;
    bit          spot;
    logic [23:0] spot_rgb;
    int          r;
    int          c;
  } item_t;

  typedef struct {
    int          ph;
    int          r;
    int          c;
    logic [23:0] rgb;
  } spot_t;

  item_t sb[$];
  spot_t spots[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    phase = 0;
  int    frow[2];
  int    fcol[2];
  bit    fen[2];

  always @(posedge clk25) cyc <= cyc + 1;

  function automatic logic [23:0] model_rgb(int r, int c);
    logic [23:0] colour [2];
    colour[0] = 24'h0000FF;
    colour[1] = 24'hFF0000;
    for (int i = 0; i < 2; i++)
      if (fen[i] && ((c-fcol[i])*(c-fcol[i]) + (r-frow[i])*(r-frow[i]) <= 900))
        return colour[i];
    return 24'hFFFFFF;
  endfunction

  function automatic int spot_val(int ph, int r, int c);
    foreach (spots[k])
      if (spots[k].ph == ph && spots[k].r == r && spots[k].c == c)
        return int'({8'h00, spots[k].rgb});
    return -1;
  endfunction

  task automatic add_spot(int ph, int r, int c, logic [23:0] v);
    spot_t s;
    s.ph = ph; s.r = r; s.c = c; s.rgb = v;
    spots.push_back(s);
  endtask

  task automatic set_obj(int i, int r, int c);
    obj_row[i*9 +: 9]  = 9'(r);
    obj_col[i*10 +: 10] = 10'(c);
  endtask

  task automatic drive_cycle(input bit h, input bit v, input bit en, input bit rv,
                             input int r, input int c);
    item_t it;
    int    sv;
    @(posedge clk25);
    #1;
    if (rv && !rst) begin
      rst = 1'b1;
      for (int k = 0; k < sb.size(); k++) begin
        sb[k].de = 1'b0;
        sb[k].rgb = '0;
        sb[k].spot = 1'b0;
      end
      #1;
      checks++;
      if ({de_out, R, G, B} !== 25'd0) begin
        errors++;
        $display("FAIL reset_async: got de=%b rgb=%02h%02h%02h, want de=0 rgb=000000",
                 de_out, R, G, B);
      end
    end else begin
      rst = rv;
    end
    Hactive = h;
    Vactive = v;
    enable  = en;
    if (rv) begin
      for (int i = 0; i < 2; i++) begin frow[i] = 0; fcol[i] = 0; fen[i] = 1'b0; end
    end else if (!v) begin
      for (int i = 0; i < 2; i++) begin
        frow[i] = int'(obj_row[i*9 +: 9]);
        fcol[i] = int'(obj_col[i*10 +: 10]);
        fen[i]  = obj_en[i];
      end
    end
    it.due = cyc + 3;
    it.de  = !rv && h && v;
    it.rgb = (it.de && en) ? model_rgb(r, c) : 24'h000000;
    it.r   = r;
    it.c   = c;
    sv = it.de ? spot_val(phase, r, c) : -1;
    it.spot = (sv >= 0);
    it.spot_rgb = sv[23:0];
    sb.push_back(it);
  endtask

  task automatic line(int r, int w, int off_lo, int off_hi);
    for (int c = 0; c < w; c++)
      drive_cycle(1'b1, 1'b1, !(c >= off_lo && c <= off_hi), 1'b0, r, c);
    for (int k = 0; k < 4; k++)
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
  endtask

  task automatic vblank(int n);
    for (int k = 0; k < n; k++)
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
  endtask

  always @(negedge clk25) begin
    item_t it;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      checks++;
      if (it.due != cyc || de_out !== it.de || {R, G, B} !== it.rgb) begin
        errors++;
        $display("FAIL pixel r=%0d c=%0d: got de=%b rgb=%02h%02h%02h, want de=%b rgb=%06h",
                 it.r, it.c, de_out, R, G, B, it.de, it.rgb);
      end
      if (it.spot) begin
        checks++;
        if ({R, G, B} !== it.spot_rgb) begin
          errors++;
          $display("FAIL spot phase=%0d (%0d,%0d): got %02h%02h%02h, want %06h",
                   phase, it.r, it.c, R, G, B, it.spot_rgb);
        end
      end
    end
  end

  initial begin
    add_spot(1, 40, 40, 24'h0000FF);
    add_spot(1, 40, 70, 24'h0000FF);
    add_spot(1, 40, 71, 24'hFFFFFF);
    add_spot(1, 70, 40, 24'h0000FF);
    add_spot(1, 71, 40, 24'hFFFFFF);
    add_spot(1, 61, 61, 24'h0000FF);
    add_spot(1, 62, 62, 24'hFFFFFF);
    add_spot(2, 40, 40, 24'h0000FF);
    add_spot(2, 50, 25, 24'h000000);
    add_spot(2, 50, 19, 24'h0000FF);
    add_spot(2, 50, 45, 24'h0000FF);
    add_spot(3, 40, 40, 24'hFF0000);
    add_spot(4, 30, 5,  24'h0000FF);
    add_spot(4, 30, 79, 24'hFFFFFF);
    add_spot(5, 30, 5,  24'hFFFFFF);
    add_spot(5, 30, 79, 24'h0000FF);
    add_spot(6, 0,  0,  24'h0000FF);
    add_spot(6, 10, 0,  24'h0000FF);
    add_spot(6, 10, 639, 24'hFFFFFF);
    add_spot(6, 15, 639, 24'hFFFFFF);
    add_spot(7, 20, 40, 24'h0000FF);
    add_spot(7, 40, 40, 24'hFFFFFF);
    add_spot(8, 40, 40, 24'h0000FF);

    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, -1, -1);

    // single blue circle, boundary pixels
    set_obj(0, 40, 40); set_obj(1, 40, 40); obj_en = 2'b01;
    vblank(3);
    phase = 1;
    for (int r = 0; r < 75; r++) line(r, 80, -1, -1);

    // overlap priority plus enable gap on row 50
    obj_en = 2'b11;
    vblank(3);
    phase = 2;
    for (int r = 0; r < 75; r++)
      if (r == 50) line(r, 80, 20, 39); else line(r, 80, -1, -1);

    obj_en = 2'b10;
    vblank(3);
    phase = 3;
    for (int r = 0; r < 75; r++) line(r, 80, -1, -1);

    // mid-frame move only shows up next frame
    set_obj(0, 30, 30); obj_en = 2'b01;
    vblank(3);
    phase = 4;
    for (int r = 0; r < 64; r++) begin
      if (r == 20) set_obj(0, 30, 50);
      line(r, 80, -1, -1);
    end
    vblank(3);
    phase = 5;
    for (int r = 0; r < 64; r++) line(r, 80, -1, -1);

    // left-edge clipping across a full-width line
    set_obj(0, 10, 5);
    vblank(3);
    phase = 6;
    for (int r = 0; r < 16; r++) line(r, 640, -1, -1);

    // reset in the middle of row 30
    set_obj(0, 40, 40);
    vblank(3);
    phase = 7;
    for (int r = 0; r < 30; r++) line(r, 80, -1, -1);
    for (int c = 0; c < 40; c++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 30, c);
    for (int c = 40; c < 43; c++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 30, c);
    for (int c = 43; c < 80; c++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 30, c);
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
    for (int r = 31; r < 51; r++) line(r, 80, -1, -1);

    vblank(3);
    phase = 8;
    for (int r = 0; r < 45; r++) line(r, 80, -1, -1);
    vblank(5);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk25);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected pixels left unchecked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
